// File: rtl/mcs4_pkg.sv
// Shared encodings for the MCS-4 style instruction sequencer: machine phases,
// sequencer states, first-word opcode values and the optional halt code.
package mcs4_pkg;

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_e;

  typedef enum logic [1:0] {
    S_SC   = 2'd0,
    S_DC   = 2'd1,
    S_HALT = 2'd2
  } state_e;

  localparam logic [3:0] OPR_JCN     = 4'h1;
  localparam logic [3:0] OPR_FIM_SRC = 4'h2;
  localparam logic [3:0] OPR_FIN_JIN = 4'h3;
  localparam logic [3:0] OPR_JUN     = 4'h4;
  localparam logic [3:0] OPR_JMS     = 4'h5;
  localparam logic [3:0] OPR_INC     = 4'h6;
  localparam logic [3:0] OPR_ISZ     = 4'h7;
  localparam logic [3:0] OPR_ADD     = 4'h8;
  localparam logic [3:0] OPR_SUB     = 4'h9;
  localparam logic [3:0] OPR_LD      = 4'hA;
  localparam logic [3:0] OPR_XCH     = 4'hB;
  localparam logic [3:0] OPR_BBL     = 4'hC;
  localparam logic [3:0] OPR_LDM     = 4'hD;
  localparam logic [3:0] OPR_IO      = 4'hE;
  localparam logic [3:0] OPR_OPE     = 4'hF;

  localparam logic [3:0] HLT_OPR = 4'h0;
  localparam logic [3:0] HLT_OPA = 4'h1;

  // FIM and FIN carry a second word only when opa[0] is clear (SRC/JIN are single).
  function automatic logic is_double(input logic [3:0] opr, input logic [3:0] opa);
    case (opr)
      OPR_JCN, OPR_ISZ, OPR_JUN, OPR_JMS: return 1'b1;
      OPR_FIM_SRC, OPR_FIN_JIN:           return ~opa[0];
      default:                            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/phase_counter.sv
// Eight-phase machine-cycle counter with sync_in realignment and a one-clock
// sync_err pulse whenever sync_in and the X3 boundary disagree.
module phase_counter
  import mcs4_pkg::*;
(
  input  logic       sysclk,
  input  logic       poc_n,
  input  logic       ph_en,
  input  logic       sync_in,
  output logic [2:0] phase,
  output logic       sync_err
);

  phase_e ph_q;

  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      ph_q     <= PH_A1;
      sync_err <= 1'b0;
    end else begin
      sync_err <= 1'b0;
      if (ph_en) begin
        // Error when sync arrives early or X3 passes without it.
        sync_err <= sync_in ^ (ph_q == PH_X3);
        ph_q     <= sync_in ? PH_A1 : phase_e'(ph_q + 3'd1);
      end
    end
  end

  assign phase = ph_q;

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: latches opcode/operand and second-word immediate from the
// nibble bus, tracks single/double/halt cycles, and decodes branch and bus controls.
module instr_sequencer
  import mcs4_pkg::*;
#(
  parameter int COND_W = 3,
  parameter int EXT_EN = 0
) (
  input  logic              sysclk,
  input  logic              poc_n,
  input  logic              ph_en,
  input  logic              sync_in,
  input  logic [3:0]        data_in,
  output logic [3:0]        data_out,
  output logic              data_oe,
  input  logic [COND_W-1:0] cond,
  input  logic              add_0,
  input  logic              resume,
  output logic [2:0]        phase,
  output logic [3:0]        opr,
  output logic [3:0]        opa,
  output logic [7:0]        imm,
  output logic              sc,
  output logic              dc,
  output logic              cn_n,
  output logic              com_n,
  output logic              halted,
  output logic              sync_err
);

  state_e state, state_nx;
  logic   step_x3;
  logic   jcn_taken;
  logic   drive;

  phase_counter u_phase (
    .sysclk   (sysclk),
    .poc_n    (poc_n),
    .ph_en    (ph_en),
    .sync_in  (sync_in),
    .phase    (phase),
    .sync_err (sync_err)
  );

  assign step_x3   = ph_en && (phase == PH_X3);
  assign jcn_taken = (|(opa[COND_W-1:0] & cond)) ^ opa[3];

  always_ff @(posedge sysclk) begin
    if (!poc_n) state <= S_SC;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (step_x3) begin
      case (state)
        S_SC: begin
          if (is_double(opr, opa))
            state_nx = S_DC;
          else if ((EXT_EN != 0) && (opr == HLT_OPR) && (opa == HLT_OPA))
            state_nx = S_HALT;
        end
        S_DC:    state_nx = S_SC;
        S_HALT:  if (resume) state_nx = S_SC;
        default: state_nx = S_SC;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (!poc_n) begin
      opr  <= 4'h0;
      opa  <= 4'h0;
      imm  <= 8'h00;
      cn_n <= 1'b1;
    end else if (ph_en) begin
      if (state == S_SC) begin
        if (phase == PH_M1) opr <= data_in;
        if (phase == PH_M2) opa <= data_in;
        if (phase == PH_X3) begin
          case (opr)
            OPR_JCN: cn_n <= ~jcn_taken;
            OPR_ISZ: cn_n <= add_0;
            default: cn_n <= 1'b1;
          endcase
        end
      end else if (state == S_DC) begin
        if (phase == PH_M1) imm[7:4] <= data_in;
        if (phase == PH_M2) imm[3:0] <= data_in;
      end
    end
  end

  assign sc     = (state == S_SC);
  assign dc     = ~sc;
  assign halted = (state == S_HALT);

  assign drive    = sc && (phase == PH_X2) &&
                    ((opr == OPR_LDM) || (opr == OPR_BBL) || (opr == OPR_JUN) || (opr == OPR_JMS));
  assign data_oe  = drive;
  assign data_out = drive ? opa : 4'h0;

  // A3 strobe is unconditional; the opcode-driven strobes are suppressed while halted.
  assign com_n = ~((phase == PH_A3) ||
                   (!halted && (((phase == PH_M2) && (opr == OPR_IO)) ||
                                ((phase == PH_X2) && (opr == OPR_FIM_SRC) && opa[0]))));

endmodule
